// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a single-port RAM: WR P(a), RMW check P(a)/write ~P(a), RD check ~P(a).
// Optional macro RAM_BIST_ERRCNT_EN: count all mismatches (err_cnt) instead of aborting on the first.
module ram_bist_ctrl #(
  parameter int             AW   = 4,
  parameter int             DW   = 4,
  parameter logic [DW-1:0]  SEED = 4'h5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] ram_qout,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [AW+1:0] err_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RMW  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic          pass_q, pass_d;
  logic          mism_q, mism_d;
`ifdef RAM_BIST_ERRCNT_EN
  logic [AW+1:0] err_cnt_q, err_cnt_d;
`endif

  logic [DW-1:0] pat;
  logic [DW-1:0] cmp_exp;
  logic          mismatch;
  logic          addr_last;
  logic          addr_first;

  assign pat        = DW'(addr_q) ^ SEED;
  assign addr_last  = (addr_q == '1);
  assign addr_first = (addr_q == '0);
  // RMW checks the pattern written by WR; RD checks the inverse written by RMW.
  assign cmp_exp    = (state_q == S_RD) ? ~pat : pat;
  assign mismatch   = ((state_q == S_RMW) || (state_q == S_RD)) && (ram_qout != cmp_exp);

  assign ram_wen   = (state_q == S_WR) || (state_q == S_RMW);
  assign ram_din   = (state_q == S_WR) ? pat : ((state_q == S_RMW) ? ~pat : '0);
  assign ram_addr  = addr_q;
  assign busy      = (state_q == S_WR) || (state_q == S_RMW) || (state_q == S_RD);
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
`ifdef RAM_BIST_ERRCNT_EN
  assign err_cnt   = err_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_addr_d = fail_addr_q;
    pass_d      = pass_q;
    mism_d      = mism_q;
`ifdef RAM_BIST_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR;
          addr_d      = '0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          mism_d      = 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
          err_cnt_d   = '0;
`endif
        end
      end
      S_WR: begin
        addr_d = addr_q + AW'(1);
        if (addr_last) begin
          state_d = S_RMW;
          addr_d  = '0;
        end
      end
      S_RMW: begin
        addr_d = addr_q + AW'(1);
        if (addr_last) begin
          state_d = S_RD;
          addr_d  = '1;
        end
      end
      S_RD: begin
        addr_d = addr_q - AW'(1);
        if (addr_first) begin
          state_d = S_FIN;
          addr_d  = '0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    if (mismatch) begin
      if (!mism_q) fail_addr_d = addr_q;
      mism_d = 1'b1;
`ifdef RAM_BIST_ERRCNT_EN
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + (AW+2)'(1);
`else
      // Abort: the RMW write of this cycle still lands since ram_wen is state-decoded.
      state_d = S_FIN;
      addr_d  = '0;
`endif
    end

    // Result is latched on entry to FIN so it is valid together with done.
    if ((state_d == S_FIN) && (state_q != S_FIN)) pass_d = !(mism_q || mismatch);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      fail_addr_q <= '0;
      pass_q      <= 1'b0;
      mism_q      <= 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_addr_q <= fail_addr_d;
      pass_q      <= pass_d;
      mism_q      <= mism_d;
`ifdef RAM_BIST_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: 16x4 RAM model with stuck-at fault injection.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ram_qout;
  logic       ram_wen;
  logic [3:0] ram_addr;
  logic [3:0] ram_din;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
`ifdef RAM_BIST_ERRCNT_EN
  logic [5:0] err_cnt;
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  ram_bist_ctrl #(.AW(4), .DW(4), .SEED(4'h5)) dut (
    .clk(clk), .clr(clr), .start(start), .ram_qout(ram_qout),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr)
`ifdef RAM_BIST_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model with per-address stuck-at masks applied on read
  logic [3:0] mem [16];
  logic [3:0] sa0 [16];
  logic [3:0] sa1 [16];
  always @(posedge clk) if (ram_wen) mem[ram_addr] <= ram_din;
  assign ram_qout = (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [3:0]  fail_addr;
    int          busy_cycles;
    logic        mem_chk;
    logic [63:0] mem;
    logic [5:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   rst_q[$];
  int   to_cnt = 0;
  bit   end_req = 1'b0;

  int checks = 0;
  int failures = 0;
  int to_seen = 0;
  bit end_done = 1'b0;
  bit prev_busy = 1'b0;
  int bcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] img;
    if (busy && !prev_busy) bcnt = 1;
    else if (busy) bcnt++;
    prev_busy = busy;

    if (rst_q.size() != 0 && rst_q[0] == cyc) begin
      void'(rst_q.pop_front());
      chk("rst_ram_wen", 64'(ram_wen), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr), 64'd0);
      chk("rst_ram_din", 64'(ram_din), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_fail_addr", 64'(fail_addr), 64'd0);
`ifdef RAM_BIST_ERRCNT_EN
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    end

    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("txn: done cycle=%0d pass=%0d fail_addr=%0d busy_cycles=%0d", cyc, pass, fail_addr, bcnt);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("pass", 64'(pass), 64'(e.pass));
        chk("fail_addr", 64'(fail_addr), 64'(e.fail_addr));
        chk("busy_cycles", 64'(bcnt), 64'(e.busy_cycles));
        chk("busy_at_done", 64'(busy), 64'd0);
`ifdef RAM_BIST_ERRCNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(e.err));
`endif
        if (e.mem_chk) begin
          for (int a = 0; a < 16; a++) img[a*4 +: 4] = mem[a];
          chk("mem_image", img, e.mem);
          chk("mem_addr0", 64'(mem[0]), 64'hA);
        end
      end
    end

    if (to_cnt != to_seen) begin
      chk("done_timeout", 64'(to_cnt), 64'(to_seen));
      to_seen = to_cnt;
    end

    if (end_req && !end_done) begin
      chk("leftover_expected_done", 64'(exp_q.size()), 64'd0);
      chk("leftover_reset_checks", 64'(rst_q.size()), 64'd0);
      end_done = 1'b1;
    end
  end

  // Stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic push(input int c, input logic p, input logic [3:0] fa, input int b,
                      input logic mc, input logic [63:0] m, input logic [5:0] er);
    exp_t e;
    e.cyc = c; e.pass = p; e.fail_addr = fa; e.busy_cycles = b;
    e.mem_chk = mc; e.mem = m; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) step(1);
    if (exp_q.size() != 0) begin
      to_cnt++;
      exp_q.delete();
    end
    step(3);
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 16; a++) begin
      sa0[a] = 4'h0;
      sa1[a] = 4'h0;
    end
  endtask

  // Final RAM image of a fault-free run: ~(a ^ 5), e.g. addr 0 -> A, addr 15 -> 5
  localparam logic [63:0] GOOD_MEM = 64'h5476_1032_DCFE_98BA;

  initial begin
    int t0;
    clear_faults();

    // reset
    step(1);
    rst_q.push_back(cyc);
    step(1);
    clr = 1'b0;
    step(2);

    // fault-free run
    pulse_start(t0);
    push(t0 + 49, 1'b1, 4'd0, 48, 1'b1, GOOD_MEM, 6'd0);
    wait_done(200);

    // addr 9 bit2 stuck-at-0: P(9)=C reads as 8 in RMW
    sa0[9] = 4'b0100;
    pulse_start(t0);
    push(ERRCNT ? t0 + 49 : t0 + 27, 1'b0, 4'd9, ERRCNT ? 48 : 26, 1'b0, 64'd0, 6'd1);
    wait_done(200);
    clear_faults();

    // addr 3 bit0 stuck-at-1: P(3)=6 reads as 7 in RMW; ~P(3)=9 passes in RD
    sa1[3] = 4'b0001;
    pulse_start(t0);
    push(ERRCNT ? t0 + 49 : t0 + 21, 1'b0, 4'd3, ERRCNT ? 48 : 20, 1'b0, 64'd0, 6'd1);
    wait_done(200);
    clear_faults();

    // clr in cycle 20 of a run, then a normal run
    pulse_start(t0);
    step(19);
    clr = 1'b1;
    rst_q.push_back(t0 + 21);
    step(1);
    clr = 1'b0;
    step(5);
    pulse_start(t0);
    push(t0 + 49, 1'b1, 4'd0, 48, 1'b1, GOOD_MEM, 6'd0);
    wait_done(200);

    // start re-pulsed in cycles 5 and 30 is ignored
    pulse_start(t0);
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(24);
    start = 1'b1;
    step(1);
    start = 1'b0;
    push(t0 + 49, 1'b1, 4'd0, 48, 1'b1, GOOD_MEM, 6'd0);
    wait_done(200);

    // start held high: FIN ignores it, IDLE in cycle 50 relaunches
    start = 1'b1;
    t0 = cyc;
    push(t0 + 49, 1'b1, 4'd0, 48, 1'b1, GOOD_MEM, 6'd0);
    push(t0 + 99, 1'b1, 4'd0, 48, 1'b1, GOOD_MEM, 6'd0);
    step(51);
    start = 1'b0;
    wait_done(300);

    // both faults: first mismatch is addr 3 (ascending RMW)
    sa0[9] = 4'b0100;
    sa1[3] = 4'b0001;
    pulse_start(t0);
    push(ERRCNT ? t0 + 49 : t0 + 21, 1'b0, 4'd3, ERRCNT ? 48 : 20, 1'b0, 64'd0, 6'd2);
    wait_done(200);
    clear_faults();

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) step(1);
    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
